// File: rtl/hub75_pkg.sv
// Shared HUB75 types and geometry, common to the panel driver and the capture block.
package hub75_pkg;

    localparam int unsigned HUB75_NUM_COLS = 64;
    localparam int unsigned HUB75_ADDR_W   = 5;

    typedef logic [2:0] rgb3_t;

    typedef struct packed {
        logic                    clk;
        logic                    latch;
        logic                    oe;
        logic [HUB75_ADDR_W-1:0] addr;
        rgb3_t                   rgb0;
        rgb3_t                   rgb1;
    } hub75_pins_t;

endpackage

// File: rtl/hub75_capture_if.sv
// HUB75 pin bundle plus the captured-line valid/ready channel toward a checker.
interface hub75_capture_if
    import hub75_pkg::*;
#(
    parameter int unsigned NUM_COLS = HUB75_NUM_COLS,
    parameter int unsigned ADDR_W   = HUB75_ADDR_W,
    parameter int unsigned ON_W     = 16
);

    logic                  hub75_clk;
    logic                  hub75_latch;
    logic                  hub75_oe;
    logic [ADDR_W-1:0]     hub75_addr;
    rgb3_t                 hub75_rgb0;
    rgb3_t                 hub75_rgb1;

    logic [NUM_COLS*3-1:0] line_rgb0;
    logic [NUM_COLS*3-1:0] line_rgb1;
    logic [ADDR_W-1:0]     line_addr;
    logic [ON_W-1:0]       line_on_cycles;
    logic                  line_valid;
    logic                  line_ready;
    logic                  len_err;
    logic                  overflow;

    // Master drives the panel pins and consumes lines; slave is the capture block.
    modport master (
        output hub75_clk, hub75_latch, hub75_oe, hub75_addr, hub75_rgb0, hub75_rgb1,
        output line_ready,
        input  line_rgb0, line_rgb1, line_addr, line_on_cycles, line_valid, len_err, overflow
    );

    modport slave (
        input  hub75_clk, hub75_latch, hub75_oe, hub75_addr, hub75_rgb0, hub75_rgb1,
        input  line_ready,
        output line_rgb0, line_rgb1, line_addr, line_on_cycles, line_valid, len_err, overflow
    );

endinterface

// File: rtl/hub75_edge_sampler.sv
// Registers the HUB75 pins once (s1) and keeps a second clk/latch stage (s2) for edge pulses.
module hub75_edge_sampler
    import hub75_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  hub75_pins_t             i_pins,
    output logic                    o_oe,
    output logic [HUB75_ADDR_W-1:0] o_addr,
    output rgb3_t                   o_rgb0,
    output rgb3_t                   o_rgb1,
    output logic                    o_shift_evt,
    output logic                    o_latch_evt
);

    hub75_pins_t r_s1;
    logic        r_s2_clk;
    logic        r_s2_latch;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_s1       <= '0;
            r_s2_clk   <= 1'b0;
            r_s2_latch <= 1'b0;
        end else begin
            r_s1       <= i_pins;
            r_s2_clk   <= r_s1.clk;
            r_s2_latch <= r_s1.latch;
        end
    end

    assign o_oe        = r_s1.oe;
    assign o_addr      = r_s1.addr;
    assign o_rgb0      = r_s1.rgb0;
    assign o_rgb1      = r_s1.rgb1;
    assign o_shift_evt = r_s1.clk & ~r_s2_clk;
    assign o_latch_evt = r_s1.latch & ~r_s2_latch;

endmodule

// File: rtl/hub75_capture.sv
// Rebuilds each shifted HUB75 line into parallel pixel data, measures OE on-time per line
// and hands completed lines to a checker over valid/ready.
module hub75_capture
    import hub75_pkg::*;
#(
    parameter int unsigned NUM_COLS = HUB75_NUM_COLS,
    parameter int unsigned ADDR_W   = HUB75_ADDR_W,
    parameter int unsigned ON_W     = 16
) (
    input logic           clk_in,
    input logic           rst_in,
    hub75_capture_if.slave bus
);

    localparam int unsigned LINE_W = NUM_COLS * 3;
    localparam int unsigned CNT_W  = $clog2(NUM_COLS + 2);

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    hub75_pins_t             w_pins_in;
    logic                    w_oe;
    logic [HUB75_ADDR_W-1:0] w_addr;
    rgb3_t                   w_rgb0;
    rgb3_t                   w_rgb1;
    logic                    w_shift_evt;
    logic                    w_latch_evt;

    logic [LINE_W-1:0]       r_sr0, r_sr1, w_sr0, w_sr1;
    logic [CNT_W-1:0]        r_shift_cnt, w_shift_cnt;
    logic [ON_W-1:0]         r_on_cnt;
    logic [0:0]              r_state, w_state_next;
    logic [LINE_W-1:0]       r_line_rgb0, r_line_rgb1;
    logic [ADDR_W-1:0]       r_line_addr;
    logic [ON_W-1:0]         r_line_on;
    logic                    r_len_err, r_overflow;
    logic                    w_valid, w_len_ok, w_commit;

    always_comb begin
        w_pins_in.clk   = bus.hub75_clk;
        w_pins_in.latch = bus.hub75_latch;
        w_pins_in.oe    = bus.hub75_oe;
        w_pins_in.addr  = bus.hub75_addr;
        w_pins_in.rgb0  = bus.hub75_rgb0;
        w_pins_in.rgb1  = bus.hub75_rgb1;
    end

    hub75_edge_sampler u_sampler (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_pins      (w_pins_in),
        .o_oe        (w_oe),
        .o_addr      (w_addr),
        .o_rgb0      (w_rgb0),
        .o_rgb1      (w_rgb1),
        .o_shift_evt (w_shift_evt),
        .o_latch_evt (w_latch_evt)
    );

    // Shift first so a coinciding latch sees the new pixel and the incremented count.
    always_comb begin
        w_sr0       = r_sr0;
        w_sr1       = r_sr1;
        w_shift_cnt = r_shift_cnt;
        if (w_shift_evt) begin
            w_sr0 = {r_sr0[LINE_W-4:0], w_rgb0};
            w_sr1 = {r_sr1[LINE_W-4:0], w_rgb1};
            if (r_shift_cnt != CNT_W'(NUM_COLS + 1)) begin
                w_shift_cnt = r_shift_cnt + 1'b1;
            end
        end
    end

    assign w_valid  = (r_state == StFull);
    assign w_len_ok = (w_shift_cnt == CNT_W'(NUM_COLS));
    assign w_commit = w_latch_evt & w_len_ok & (~w_valid | bus.line_ready);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StEmpty: if (w_commit) w_state_next = StFull;
            StFull:  if (!w_commit && bus.line_ready) w_state_next = StEmpty;
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sr0       <= '0;
            r_sr1       <= '0;
            r_shift_cnt <= '0;
            r_on_cnt    <= '0;
            r_state     <= StEmpty;
            r_line_rgb0 <= '0;
            r_line_rgb1 <= '0;
            r_line_addr <= '0;
            r_line_on   <= '0;
            r_len_err   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_sr0       <= w_sr0;
            r_sr1       <= w_sr1;
            r_shift_cnt <= w_latch_evt ? '0 : w_shift_cnt;
            r_state     <= w_state_next;
            // The latch cycle itself never counts toward either line's on-time.
            if (w_latch_evt) begin
                r_on_cnt <= '0;
            end else if (!w_oe && !(&r_on_cnt)) begin
                r_on_cnt <= r_on_cnt + 1'b1;
            end
            if (w_commit) begin
                r_line_rgb0 <= w_sr0;
                r_line_rgb1 <= w_sr1;
                r_line_addr <= w_addr;
                r_line_on   <= r_on_cnt;
            end
            if (w_latch_evt && !w_len_ok) begin
                r_len_err <= 1'b1;
            end
            if (w_latch_evt && w_len_ok && !w_commit) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.line_valid     = w_valid;
    assign bus.line_rgb0      = r_line_rgb0;
    assign bus.line_rgb1      = r_line_rgb1;
    assign bus.line_addr      = r_line_addr;
    assign bus.line_on_cycles = r_line_on;
    assign bus.len_err        = r_len_err;
    assign bus.overflow       = r_overflow;

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receive-side counterpart of the HUB75 panel driver: samples the HUB75 pins (clk, latch, OE, addr, rgb0/rgb1) and reconstructs each shifted line as parallel pixel data.
- Also measures how long OE was asserted for each line.
- Used in loopback/self-check builds: driver outputs feed this block, and the recovered lines are compared against frame data.
- The block itself carries the HUB75 inputs and a valid/ready output toward a checker.

Parameters:
- NUM_COLS, 64, pixels shifted per line (led_clk rising edges per latch).
- ADDR_W, 5, width of hub75_addr.
- ON_W, 16, width of the OE on-time counter.

Ports:
- clk_in  input  1  system clock; all HUB75 inputs are driven from this domain.
- rst_in  input  1  asynchronous active-low reset.
- hub75_clk  input  1  panel shift clock.
- hub75_latch  input  1  panel latch.
- hub75_oe  input  1  output enable, active-low.
- hub75_addr  input  ADDR_W  row address.
- hub75_rgb0  input  3  upper-half pixel bits.
- hub75_rgb1  input  3  lower-half pixel bits.
- line_rgb0  output  NUM_COLS*3  captured upper line; index NUM_COLS-1 = first pixel shifted.
- line_rgb1  output  NUM_COLS*3  captured lower line.
- line_addr  output  ADDR_W  hub75_addr sampled at the latch edge.
- line_on_cycles  output  ON_W  clk_in cycles with OE low between the previous latch edge and this latch edge.
- line_valid  output  1  captured line available.
- line_ready  input  1  consumer accepts.
- len_err  output  1  sticky: a latch arrived with shift count != NUM_COLS.
- overflow  output  1  sticky: a latch arrived while line_valid=1 and line_ready=0.

Behaviour:
- Input stage: every HUB75 input is registered once (stage s1), with a second stage s2 kept for edge detection. All decisions use s1/s2. Fixed input-to-decision latency is 1 cycle.
- Shift event: s1.clk=1 and s2.clk=0.
  - Shift s1.rgb0 and s1.rgb1 into their shift registers at index 0; existing contents move toward NUM_COLS-1.
  - shift_cnt increments and saturates at NUM_COLS+1 (width $clog2(NUM_COLS+2)).
- Latch event: s1.latch=1 and s2.latch=0.
  - If shift_cnt == NUM_COLS and the output register is free (line_valid=0, or line_ready=1 this cycle): copy the shift registers to line_rgb0/1, s1.addr to line_addr, and on_cnt to line_on_cycles. line_valid=1 the following cycle.
  - If shift_cnt != NUM_COLS: drop the line, set len_err. line_valid is unchanged.
  - If the count is correct but the output is occupied and not accepted: drop the line, set overflow. The held line is kept.
  - In all three cases, clear shift_cnt and on_cnt in the same cycle.
- Shift and latch in the same cycle: the shift is applied first and counted, then the latch is evaluated with the incremented count.
- on_cnt: increments every cycle s1.oe=0, saturates at 2^ON_W-1, and clears on a latch event.
  - If the latch coincides with OE low, that cycle is not counted into the committed value; the new count starts at 0.
- Output handshake:
  - Transfer occurs when line_valid && line_ready.
  - Outputs stay stable while line_valid=1 and line_ready=0.
  - A transfer with no new commit clears line_valid the next cycle.
  - Back-to-back commit and transfer in the same cycle is legal: line_valid stays 1 with the new data.
- State machine (output register):
  - EMPTY -> FULL on commit.
  - FULL -> EMPTY on transfer without commit.
  - FULL -> FULL on commit with concurrent transfer.
- Sticky flags clear only on reset.
- Reset (asynchronous, active-low):
  - All outputs go to 0: line_valid, line_rgb0/1, line_addr, line_on_cycles, len_err, overflow.
  - Internal shift registers, counters and the s1/s2 stages also go to 0.
  - Reset mid-line discards the partial line.
  - Because s2.clk and s2.latch reset to 0, an input already high at reset release produces one edge event. This is accepted; the resulting line is flagged via len_err unless it is complete.

Decomposition:
- Shared package hub75_pkg:
  - typedef rgb3_t (logic [2:0]).
  - typedef hub75_pins_t struct {clk, latch, oe, addr, rgb0, rgb1}.
  - constants HUB75_NUM_COLS=64 and HUB75_ADDR_W=5, shared with the panel driver.
- One sub-module: hub75_edge_sampler. It holds the s1/s2 registers for hub75_pins_t and outputs the registered pins plus shift_evt and latch_evt pulses.
- Line assembly, counters and the output handshake stay in hub75_capture.

Test Plan:
- Complete line: 64 shifts, pixel k = k[2:0] on rgb0 and ~k[2:0] on rgb1; addr=5; latch; line_ready=1 -> one line_valid pulse. line_rgb0[63]=0, line_rgb0[0]=7, line_rgb1[0]=0, line_addr=5.
- On-time: OE low for exactly 200 cycles between two full latched lines -> second line's line_on_cycles=200.
- Short line: 63 shifts then latch -> no line_valid, len_err=1. The next full 64-shift line commits normally and len_err stays 1.
- Backpressure: line_ready=0, two full lines latched -> first line held unchanged, overflow=1. Raising line_ready then transfers the first line only.
- Same-cycle shift+latch after 63 prior shifts -> commit succeeds, with the 64th pixel at index 0.
- Reset mid-line: rst_in low after 30 shifts, release, 64 shifts plus latch -> valid line with correct data; all flags 0 after release.
